// File: rtl/madd_sched_pkg.sv
// ============================================================================
// Module      : madd_sched_pkg
// Description : Shared constants, ID-width helper and result-FIFO entry type
//               for the multiply-add issue scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package madd_sched_pkg;

    localparam int c_DATA_W   = 32;
    localparam int c_ID_MAX_W = 3;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // id is sized for the largest requester count; narrower builds zero-extend.
    typedef struct packed {
        logic [c_DATA_W-1:0]   z;
        logic [c_ID_MAX_W-1:0] id;
    } fifo_entry_t;

endpackage

`default_nettype wire

// File: rtl/madd_sched_fifo.sv
// ============================================================================
// Module      : madd_sched_fifo
// Description : Synchronous DEPTH-entry result FIFO with push/pop/full/empty/count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module madd_sched_fifo
    import madd_sched_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int c_PW  = $clog2(DEPTH),
    localparam int c_CW  = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_push,
    input  fifo_entry_t     i_data,
    input  logic            i_pop,
    output fifo_entry_t     o_data,
    output logic            o_full,
    output logic            o_empty,
    output logic [c_CW-1:0] o_count
);

    fifo_entry_t     r_mem [DEPTH];
    logic [c_PW-1:0] r_wptr;
    logic [c_PW-1:0] r_rptr;
    logic [c_CW-1:0] r_count;
    logic            w_pop;

    assign o_full  = (r_count == c_CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rptr];
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= (r_wptr == c_PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            end
            if (i_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!i_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(i_push && o_full && !w_pop));
        end
    end

endmodule

`default_nettype wire

// File: rtl/madd_sched.sv
// ============================================================================
// Module      : madd_sched
// Description : Arbitrates NREQ requesters into an external 2-stage MADD unit
//               and returns results with requester ID through a credited FIFO.
//               Define MADD_SCHED_RR_EN for round-robin, else fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module madd_sched
    import madd_sched_pkg::*;
#(
    parameter int  NREQ  = 4,
    parameter int  DEPTH = 4,
    localparam int ID_W  = id_width(NREQ),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*c_DATA_W-1:0] req_a,
    input  logic [NREQ*c_DATA_W-1:0] req_b,
    input  logic [NREQ*c_DATA_W-1:0] req_c,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [c_DATA_W-1:0]      resp_z,
    output logic [ID_W-1:0]          resp_id,
    output logic [c_DATA_W-1:0]      madd_a,
    output logic [c_DATA_W-1:0]      madd_b,
    output logic [c_DATA_W-1:0]      madd_c,
    input  logic [c_DATA_W-1:0]      madd_z
);

    logic [c_DATA_W-1:0] r_madd_a, r_madd_b, r_madd_c, r_c_hold;
    logic                r_s1_v, r_s2_v;
    logic [ID_W-1:0]     r_s1_id, r_s2_id;
    logic [CNT_W-1:0]    r_cnt;
    logic [ID_W-1:0]     w_win;
    logic                w_any, w_issue, w_pop, w_full, w_empty;
    logic [CNT_W-1:0]    w_fifo_count;
    fifo_entry_t         w_push_data, w_head;

`ifdef MADD_SCHED_RR_EN
    logic [ID_W-1:0]     r_ptr;

    // Descending scan so the last hit is the first valid at or after the pointer.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(r_ptr) + k) % NREQ]) begin
                w_any = 1'b1;
                w_win = ID_W'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ptr <= '0;
        end else if (w_issue) begin
            r_ptr <= (w_win == ID_W'(NREQ - 1)) ? '0 : w_win + 1'b1;
        end
    end
`else
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                w_any = 1'b1;
                w_win = ID_W'(k);
            end
        end
    end
`endif

    assign w_issue   = w_any && (r_cnt < CNT_W'(DEPTH)) && !RST;
    assign req_ready = w_issue ? (NREQ'(1) << w_win) : '0;
    assign w_pop     = resp_valid & resp_ready;

    // C trails A/B by one stage because the unit consumes it after its carry-save latch.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_madd_a <= '0;
            r_madd_b <= '0;
            r_madd_c <= '0;
            r_c_hold <= '0;
            r_s1_v   <= 1'b0;
            r_s2_v   <= 1'b0;
            r_s1_id  <= '0;
            r_s2_id  <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_issue) begin
                r_madd_a <= req_a[c_DATA_W*w_win +: c_DATA_W];
                r_madd_b <= req_b[c_DATA_W*w_win +: c_DATA_W];
                r_c_hold <= req_c[c_DATA_W*w_win +: c_DATA_W];
                r_s1_id  <= w_win;
            end else begin
                r_madd_a <= '0;
                r_madd_b <= '0;
            end
            r_s1_v   <= w_issue;
            r_madd_c <= r_s1_v ? r_c_hold : '0;
            r_s2_v   <= r_s1_v;
            r_s2_id  <= r_s1_id;
            if (w_issue && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_issue && w_pop) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign madd_a = r_madd_a;
    assign madd_b = r_madd_b;
    assign madd_c = r_madd_c;

    assign w_push_data = '{z: madd_z, id: c_ID_MAX_W'(r_s2_id)};

    madd_sched_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .i_push  (r_s2_v),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_fifo_count)
    );

    assign resp_valid = ~w_empty;
    assign resp_z     = w_head.z;
    assign resp_id    = ID_W'(w_head.id);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            assert (r_cnt <= CNT_W'(DEPTH) && w_fifo_count <= r_cnt);
            assert (!(r_s2_v && w_full && !w_pop));
        end
    end

endmodule

`default_nettype wire
